// File: rtl/fft_frame_sender_pkg.sv
// Shared types and helpers for the FFT frame sender slice.
package fft_stream_pkg;

  localparam int unsigned MAX_PTS  = 128;
  localparam int unsigned MIN_PTS  = 8;
  localparam int unsigned SAMPLE_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  // One queued output beat: complex sample plus its framing tags.
  typedef struct packed {
    logic [SAMPLE_W-1:0] re;
    logic [SAMPLE_W-1:0] im;
    logic                sop;
    logic                eop;
  } payload_t;

  localparam int unsigned PAYLOAD_W = $bits(payload_t);

  // A frame size is legal when it is a power of two between MIN_PTS and max_pts.
  function automatic logic is_legal_pts(input int unsigned pts, input int unsigned max_pts);
    return (pts >= MIN_PTS) && (pts <= max_pts) && ((pts & (pts - 1)) == 0);
  endfunction

endpackage

// File: rtl/fft_frame_sender_if.sv
// Avalon-ST source bundle toward the FFT sink (readyLatency 0).
interface fft_st_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PTS_W  = 8
);
  logic              out_valid;
  logic              out_ready;
  logic              out_sop;
  logic              out_eop;
  logic [1:0]        out_error;
  logic [DATA_W-1:0] out_real;
  logic [DATA_W-1:0] out_imag;
  logic [PTS_W-1:0]  out_fftpts;

  modport master (
    output out_valid, out_sop, out_eop, out_error, out_real, out_imag, out_fftpts,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_sop, out_eop, out_error, out_real, out_imag, out_fftpts,
    output out_ready
  );
endinterface

// File: rtl/fft_frame_sender_fifo.sv
// Two-entry fall-through FIFO: a write into an empty FIFO is visible on
// rd_data in the same cycle, so RAM data reaches the stream without a bubble.
module fft_skid_fifo #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             valid,
  output logic [1:0]       count
);
  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       cnt;
  logic             bypass;
  logic             store;
  logic             pop_mem;

  // Output selection and storage decisions; a bypassed word popped at once is never stored.
  always_comb begin
    bypass  = (cnt == 2'd0) && wr_en;
    valid   = (cnt != 2'd0) || wr_en;
    rd_data = '0;
    if (cnt != 2'd0) begin
      rd_data = mem[rd_ptr];
    end else if (wr_en) begin
      rd_data = wr_data;
    end
    pop_mem = pop && (cnt != 2'd0);
    store   = wr_en && !(bypass && pop);
  end

  // Pointer, occupancy and storage update.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (store) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_mem) begin
        rd_ptr <= ~rd_ptr;
      end
      cnt <= cnt + 2'(store) - 2'(pop_mem);
    end
  end

  assign count = cnt;

endmodule

// File: rtl/fft_frame_sender.sv
// Reads complex samples from a 1-cycle-latency RAM and streams them out as
// back-to-back FFT frames with sop/eop framing and a held point count.
module fft_frame_sender #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned PTS_W   = 8,
  parameter int unsigned MAX_PTS = fft_stream_pkg::MAX_PTS,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned FRM_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [PTS_W-1:0]  frame_pts,
  input  logic [FRM_W-1:0]  num_frames,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_real,
  input  logic [DATA_W-1:0] rd_imag,
  fft_st_if.master          st
);
  import fft_stream_pkg::*;

  localparam int unsigned TOT_W = PTS_W + FRM_W;

  state_t             state_q;
  state_t             state_d;
  logic [PTS_W-1:0]   pts_q;
  logic [PTS_W-1:0]   pos_q;
  logic [PTS_W-1:0]   pos_last;
  logic [ADDR_W-1:0]  addr_q;
  logic [TOT_W-1:0]   remain_q;
  logic [TOT_W-1:0]   total;
  logic [FRM_W-1:0]   nf_eff;
  logic [PTS_W-1:0]   fftpts_q;
  logic               cfg_err_q;
  logic               inflight_q;
  logic               tag_sop_q;
  logic               tag_eop_q;
  logic               legal;
  logic               start_idle;
  logic [1:0]         fifo_count;
  logic               fifo_valid;
  payload_t           wr_payload;
  payload_t           rd_payload;
  logic [PAYLOAD_W-1:0] rd_bits;

  assign legal      = is_legal_pts(32'(frame_pts), MAX_PTS);
  assign start_idle = start && (state_q == IDLE);
  assign nf_eff     = (num_frames == '0) ? FRM_W'(1) : num_frames;
  assign total      = TOT_W'(frame_pts) * TOT_W'(nf_eff);
  assign pos_last   = pts_q - PTS_W'(1);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, read strobe and completion pulse.
  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && legal) begin
          state_d = RUN;
        end
      end
      RUN: begin
        rd_en = (3'(fifo_count) + 3'(inflight_q)) < 3'd2;
        if (rd_en && (remain_q == TOT_W'(1))) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if ((fifo_count == 2'd0) && !inflight_q) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE) && !done;

  // Transfer bookkeeping: latch config on an accepted start, advance on each read.
  always_ff @(posedge clk) begin
    if (rst) begin
      pts_q      <= '0;
      pos_q      <= '0;
      addr_q     <= '0;
      remain_q   <= '0;
      fftpts_q   <= '0;
      cfg_err_q  <= 1'b0;
      inflight_q <= 1'b0;
      tag_sop_q  <= 1'b0;
      tag_eop_q  <= 1'b0;
    end else begin
      cfg_err_q  <= start_idle && !legal;
      inflight_q <= rd_en;
      tag_sop_q  <= rd_en && (pos_q == '0);
      tag_eop_q  <= rd_en && (pos_q == pos_last);
      if (start_idle && legal) begin
        pts_q    <= frame_pts;
        fftpts_q <= frame_pts;
        addr_q   <= base_addr;
        remain_q <= total;
        pos_q    <= '0;
      end else if (rd_en) begin
        addr_q   <= addr_q + ADDR_W'(1);
        remain_q <= remain_q - TOT_W'(1);
        pos_q    <= (pos_q == pos_last) ? '0 : pos_q + PTS_W'(1);
      end
    end
  end

  assign cfg_err = cfg_err_q;
  assign rd_addr = addr_q;

  // Tags travel alongside the read so they land in the FIFO with their data.
  always_comb begin
    wr_payload     = '0;
    wr_payload.re  = rd_real;
    wr_payload.im  = rd_imag;
    wr_payload.sop = tag_sop_q;
    wr_payload.eop = tag_eop_q;
  end

  fft_skid_fifo #(
    .WIDTH(PAYLOAD_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (inflight_q),
    .wr_data (wr_payload),
    .pop     (fifo_valid && st.out_ready),
    .rd_data (rd_bits),
    .valid   (fifo_valid),
    .count   (fifo_count)
  );

  assign rd_payload    = payload_t'(rd_bits);
  assign st.out_valid  = fifo_valid;
  assign st.out_real   = rd_payload.re;
  assign st.out_imag   = rd_payload.im;
  assign st.out_sop    = rd_payload.sop;
  assign st.out_eop    = rd_payload.eop;
  assign st.out_error  = 2'b00;
  assign st.out_fftpts = fftpts_q;

endmodule

// File: tb/tb_fft_frame_sender.sv
// Self-checking bench for fft_frame_sender: table-driven transfers plus
// hand-written timing, busy-start and mid-frame reset sequences.
module tb_fft_frame_sender;

  localparam int unsigned PTS_W = 9;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [PTS_W-1:0] frame_pts;
  logic [7:0]       num_frames;
  logic [9:0]       base_addr;
  logic             busy, done, cfg_err, rd_en;
  logic [9:0]       rd_addr;
  logic [31:0]      rd_real = '0;
  logic [31:0]      rd_imag = '0;

  fft_st_if #(.DATA_W(32), .PTS_W(PTS_W)) st_bus ();

  fft_frame_sender #(
    .DATA_W(32), .PTS_W(PTS_W), .MAX_PTS(128), .ADDR_W(10), .FRM_W(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .frame_pts(frame_pts),
    .num_frames(num_frames), .base_addr(base_addr), .busy(busy), .done(done),
    .cfg_err(cfg_err), .rd_en(rd_en), .rd_addr(rd_addr), .rd_real(rd_real),
    .rd_imag(rd_imag), .st(st_bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ram_re(input logic [9:0] a);
    return 32'hA500_0000 ^ (32'(a) * 32'h0001_0003);
  endfunction

  function automatic logic [31:0] ram_im(input logic [9:0] a);
    return 32'h3C00_0000 + 32'(a) * 32'd7 + 32'd1;
  endfunction

  // RAM model: data valid only in the cycle after rd_en, garbage otherwise.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_real <= ram_re(rd_addr);
      rd_imag <= ram_im(rd_addr);
    end else begin
      rd_real <= 32'hDEAD_BEEF;
      rd_imag <= 32'hBAD0_BAD0;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Ready generator: mode 0 holds ready high, mode 1 walks 1,0,0,1 with random flips.
  int rmode = 0;
  int ph = 0;
  logic [3:0] pat = 4'b1001;
  initial begin
    st_bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rmode == 0) begin
        st_bus.out_ready = 1'b1;
      end else begin
        st_bus.out_ready = pat[ph];
        ph = (ph + 1) % 4;
        if ($urandom_range(0, 3) == 0) st_bus.out_ready = !st_bus.out_ready;
      end
    end
  end

  typedef struct {
    logic [31:0]      re;
    logic [31:0]      im;
    logic             sop;
    logic             eop;
    logic [PTS_W-1:0] pts;
    int               cyc;
  } sample_t;

  sample_t q[$];
  int rd_cnt, acc_cnt, max_out, done_cnt, cfg_cnt, cfg_cyc, busy_cnt;
  int t0 = 0;
  bit trace_en = 0;
  logic [31:0] tr_rd, tr_val, tr_sop, tr_eop, tr_done, tr_busy;
  logic        stall_prev = 0;
  logic [65:0] held;

  // Stream monitor: collects accepted beats, checks stalls, tallies pulses.
  always @(negedge clk) begin
    logic [65:0] cur;
    sample_t s;
    int k;
    if (rst) begin
      stall_prev = 0;
    end else begin
      if (rd_en) rd_cnt++;
      if (rd_cnt - acc_cnt > max_out) max_out = rd_cnt - acc_cnt;
      cur = {st_bus.out_real, st_bus.out_imag, st_bus.out_sop, st_bus.out_eop};
      if (stall_prev) begin
        chk("stall_valid_held", st_bus.out_valid, 1'b1);
        chk("stall_payload_held", cur, held);
      end
      if (st_bus.out_valid && st_bus.out_ready) begin
        s.re = st_bus.out_real; s.im = st_bus.out_imag;
        s.sop = st_bus.out_sop; s.eop = st_bus.out_eop;
        s.pts = st_bus.out_fftpts; s.cyc = cyc;
        q.push_back(s);
        acc_cnt++;
      end
      stall_prev = st_bus.out_valid && !st_bus.out_ready;
      held = cur;
      if (done) done_cnt++;
      if (cfg_err) begin cfg_cnt++; cfg_cyc = cyc; end
      if (busy) busy_cnt++;
      if (trace_en && cyc >= t0 && cyc - t0 < 32) begin
        k = cyc - t0;
        tr_rd[k] = rd_en; tr_val[k] = st_bus.out_valid;
        tr_sop[k] = st_bus.out_sop; tr_eop[k] = st_bus.out_eop;
        tr_done[k] = done; tr_busy[k] = busy;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    q.delete();
    rd_cnt = 0; acc_cnt = 0; max_out = 0; done_cnt = 0;
    cfg_cnt = 0; cfg_cyc = -1; busy_cnt = 0;
    tr_rd = '0; tr_val = '0; tr_sop = '0; tr_eop = '0; tr_done = '0; tr_busy = '0;
  endtask

  task automatic do_start(input int pts, input int nf, input int base);
    frame_pts  = PTS_W'(pts);
    num_frames = 8'(nf);
    base_addr  = 10'(base);
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 3000 && done_cnt == 0; i++) tick();
    chk({tag, "_done_seen"}, done_cnt, 1);
  endtask

  task automatic check_samples(input int pts, input int n, input int base, input string tag);
    logic [9:0]  a;
    logic [74:0] act, exp;
    chk({tag, "_sample_count"}, q.size(), n);
    for (int i = 0; i < q.size() && i < n; i++) begin
      a   = 10'((base + i) % 1024);
      exp = {ram_re(a), ram_im(a), 1'((i % pts) == 0), 1'((i % pts) == pts - 1), PTS_W'(pts)};
      act = {q[i].re, q[i].im, q[i].sop, q[i].eop, q[i].pts};
      chk($sformatf("%s_s%0d", tag, i), act, exp);
    end
  endtask

  typedef struct {
    int pts;
    int nf;
    int base;
    int rm;
    int exp_n;
    bit exp_cfg;
  } vec_t;

  task automatic run_vec(input vec_t v, input string tag);
    clear_stats();
    rmode = v.rm;
    t0 = cyc;
    do_start(v.pts, v.nf, v.base);
    if (v.exp_cfg) begin
      repeat (8) tick();
      chk({tag, "_cfg_err_pulses"}, cfg_cnt, 1);
      chk({tag, "_cfg_err_cycle"}, cfg_cyc - t0, 1);
      chk({tag, "_no_reads"}, rd_cnt, 0);
      chk({tag, "_busy_cycles"}, busy_cnt, 0);
      chk({tag, "_no_done"}, done_cnt, 0);
      chk({tag, "_no_output"}, q.size(), 0);
    end else begin
      wait_done(tag);
      repeat (2) tick();
      chk({tag, "_done_pulses"}, done_cnt, 1);
      chk({tag, "_no_cfg_err"}, cfg_cnt, 0);
      chk({tag, "_reads"}, rd_cnt, v.exp_n);
      chk({tag, "_outstanding_le2"}, max_out <= 2, 1'b1);
      chk({tag, "_busy_after"}, busy, 1'b0);
      check_samples(v.pts, v.exp_n, v.base, tag);
      if (v.rm == 0 && q.size() == v.exp_n)
        chk({tag, "_no_gap"}, q[v.exp_n - 1].cyc - q[0].cyc, v.exp_n - 1);
    end
    rmode = 0;
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{pts: 8,   nf: 1, base: 0,    rm: 0, exp_n: 8,   exp_cfg: 0};
    vecs[1] = '{pts: 16,  nf: 1, base: 40,   rm: 1, exp_n: 16,  exp_cfg: 0};
    vecs[2] = '{pts: 128, nf: 3, base: 1000, rm: 0, exp_n: 384, exp_cfg: 0};
    vecs[3] = '{pts: 12,  nf: 1, base: 0,    rm: 0, exp_n: 0,   exp_cfg: 1};
    vecs[4] = '{pts: 256, nf: 1, base: 0,    rm: 0, exp_n: 0,   exp_cfg: 1};
    vecs[5] = '{pts: 8,   nf: 0, base: 1020, rm: 0, exp_n: 8,   exp_cfg: 0};
    vecs[6] = '{pts: 32,  nf: 2, base: 500,  rm: 1, exp_n: 64,  exp_cfg: 0};
    vecs[7] = '{pts: 0,   nf: 1, base: 0,    rm: 0, exp_n: 0,   exp_cfg: 1};

    rst = 1'b1; start = 1'b0; frame_pts = '0; num_frames = '0; base_addr = '0;
    clear_stats();
    repeat (3) tick();
    chk("reset_outputs",
        {busy, done, cfg_err, rd_en, rd_addr, st_bus.out_valid, st_bus.out_sop,
         st_bus.out_eop, st_bus.out_error, st_bus.out_fftpts, st_bus.out_real, st_bus.out_imag}, '0);
    rst = 1'b0;
    repeat (2) tick();

    for (int v = 0; v < 8; v++) begin
      trace_en = (v == 0);
      run_vec(vecs[v], $sformatf("vec%0d", v));
      trace_en = 0;
      if (v == 0) begin
        chk("t0_rd_en_window",  tr_rd,   32'h0000_01FE);
        chk("t0_valid_window",  tr_val,  32'h0000_03FC);
        chk("t0_sop_cycle",     tr_sop,  32'h0000_0004);
        chk("t0_eop_cycle",     tr_eop,  32'h0000_0200);
        chk("t0_done_cycle",    tr_done, 32'h0000_0400);
        chk("t0_busy_window",   tr_busy, 32'h0000_03FE);
      end
    end

    // Starts while busy are ignored: no cfg_err, original transfer unchanged.
    clear_stats();
    do_start(16, 1, 100);
    repeat (4) tick();
    do_start(12, 2, 500);
    repeat (2) tick();
    do_start(32, 1, 700);
    wait_done("busy_start");
    repeat (2) tick();
    chk("busy_start_no_cfg_err", cfg_cnt, 0);
    chk("busy_start_done_pulses", done_cnt, 1);
    chk("busy_start_reads", rd_cnt, 16);
    check_samples(16, 16, 100, "busy_start");

    // Reset after five of eight samples: immediate abort, no done pulse.
    clear_stats();
    do_start(8, 1, 200);
    for (int i = 0; i < 50 && q.size() < 5; i++) tick();
    chk("rst_mid_reached_5", q.size() >= 5, 1'b1);
    rst = 1'b1;
    tick();
    chk("rst_mid_outputs",
        {busy, done, cfg_err, rd_en, rd_addr, st_bus.out_valid, st_bus.out_sop,
         st_bus.out_eop, st_bus.out_error, st_bus.out_fftpts, st_bus.out_real, st_bus.out_imag}, '0);
    rst = 1'b0;
    repeat (6) tick();
    chk("rst_mid_no_done", done_cnt, 0);
    run_vec('{pts: 8, nf: 1, base: 300, rm: 1, exp_n: 8, exp_cfg: 0}, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
